// File: rtl/poker_table_video_if.sv
// Card/hand types and the game-to-video signal bundle for poker_table_video.
// slave: the video back end; master: the game FSM side (also receives the video outputs).
package poker_types_pkg;
    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
    } card_t;

    localparam logic [1:0] SuitClubs    = 2'd0;
    localparam logic [1:0] SuitDiamonds = 2'd1;
    localparam logic [1:0] SuitHearts   = 2'd2;
    localparam logic [1:0] SuitSpades   = 2'd3;

    typedef enum logic [2:0] {
        StPreflop  = 3'd0,
        StFlop     = 3'd1,
        StTurn     = 3'd2,
        StRiver    = 3'd3,
        StShowdown = 3'd4
    } hand_state_t;
endpackage

interface poker_table_video_if;
    import poker_types_pkg::*;

    logic [2:0]        player_count;
    card_t [1:0][1:0]  player_cards;
    logic [1:0][10:0]  player_stacks;
    logic [1:0][10:0]  player_pots;
    logic [10:0]       pot_size;
    logic              current_player;
    logic              current_dealer;
    logic              winner;
    logic              if_BetCheck;
    card_t [2:0]       flop_card;
    card_t             turn_card;
    card_t             river_card;
    hand_state_t       curr_state;
    logic              start_state;
    logic              wait_state;
    logic              game_state;

    logic              hs;
    logic              vs;
    logic              active_nblank;
    logic              sync;
    logic [9:0]        drawX;
    logic [9:0]        drawY;
    logic [3:0]        Red;
    logic [3:0]        Green;
    logic [3:0]        Blue;

    modport master (
        output player_count, player_cards, player_stacks, player_pots, pot_size,
               current_player, current_dealer, winner, if_BetCheck, flop_card, turn_card,
               river_card, curr_state, start_state, wait_state, game_state,
        input  hs, vs, active_nblank, sync, drawX, drawY, Red, Green, Blue
    );

    modport slave (
        input  player_count, player_cards, player_stacks, player_pots, pot_size,
               current_player, current_dealer, winner, if_BetCheck, flop_card, turn_card,
               river_card, curr_state, start_state, wait_state, game_state,
        output hs, vs, active_nblank, sync, drawX, drawY, Red, Green, Blue
    );
endinterface

// File: rtl/poker_table_video.sv
// 800x525 VGA timing generator fused with the poker table renderer (zero-latency RGB).
// Optional feature: define SHOW_ALL_CARDS_EN to draw every hole card face-up.
module poker_table_video
    import poker_types_pkg::*;
#(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned CARD_W  = 40,
    parameter int unsigned CARD_H  = 56
) (
    input  logic              clk,
    input  logic              reset,
    poker_table_video_if.slave vid
);

    logic [9:0] draw_x_q, draw_x_d;
    logic [9:0] draw_y_q, draw_y_d;
    logic       hs_q, vs_q;

    always_comb begin
        draw_x_d = draw_x_q + 10'd1;
        draw_y_d = draw_y_q;
        if (draw_x_q == 10'(H_TOTAL - 1)) begin
            draw_x_d = '0;
            draw_y_d = (draw_y_q == 10'(V_TOTAL - 1)) ? '0 : draw_y_q + 10'd1;
        end
    end

    // Sync levels are computed from the next position so they line up with drawX/drawY.
    always_ff @(posedge clk) begin
        if (reset) begin
            draw_x_q <= '0;
            draw_y_q <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else begin
            draw_x_q <= draw_x_d;
            draw_y_q <= draw_y_d;
            hs_q     <= !(draw_x_d >= 10'd656 && draw_x_d <= 10'd751);
            vs_q     <= !(draw_y_d >= 10'd490 && draw_y_d <= 10'd491);
        end
    end

    function automatic logic in_rect(logic [10:0] x, logic [10:0] y, logic [10:0] x0,
                                     logic [10:0] y0, logic [10:0] w, logic [10:0] h);
        return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
    endfunction

    function automatic logic [10:0] cap_len(logic [10:0] v, logic [10:0] cap);
        return (v > cap) ? cap : v;
    endfunction

    // Returns {hit, rgb} for one card whose top-left corner is (x0, y0).
    function automatic logic [12:0] card_px(logic [10:0] x, logic [10:0] y, logic [10:0] x0,
                                            logic [10:0] y0, card_t c, logic up);
        logic [10:0] rx, ry;
        logic [11:0] ink;
        logic [12:0] res;
        rx  = x - x0;
        ry  = y - y0;
        ink = (c.suit == SuitDiamonds || c.suit == SuitHearts) ? 12'hF00 : 12'h000;
        res = '0;
        if (in_rect(x, y, x0, y0, 11'(CARD_W), 11'(CARD_H))) begin
            if (!up) begin
                res = {1'b1, 12'h00A};
            end else if (rx >= 11'd4 && rx <= 11'd11 && ry >= 11'd4 && ry <= 11'd11) begin
                res = {1'b1, ink};
            end else if (ry >= 11'd44 && ry <= 11'd51 && rx >= 11'd4 &&
                         rx < 11'd4 + {6'd0, c.rank, 1'b0}) begin
                res = {1'b1, ink};
            end else begin
                res = {1'b1, 12'hFFF};
            end
        end
        return res;
    endfunction

    logic [10:0]      px, py;
    logic             active;
    logic             p1_en, showdown, owner, face_up;
    logic [2:0]       comm_vis;
    card_t [4:0]      comm_cards;
    logic [1:0][10:0] stack_len, bet_len;
    logic [10:0]      pot_len, frame_top, dealer_top;
    logic [12:0]      hit;
    logic [11:0]      rgb;

    assign px         = {1'b0, draw_x_q};
    assign py         = {1'b0, draw_y_q};
    assign active     = (draw_x_q < 10'd640) && (draw_y_q < 10'd480);
    assign p1_en      = vid.player_count >= 3'd2;
    assign showdown   = vid.curr_state == StShowdown;
    assign owner      = showdown ? vid.winner : vid.current_player;
    assign frame_top  = owner ? 11'd20 : 11'd396;
    assign dealer_top = vid.current_dealer ? 11'd46 : 11'd422;
    assign comm_cards = {vid.river_card, vid.turn_card, vid.flop_card};
    assign pot_len    = cap_len(vid.pot_size >> 5, 11'd240);

    for (genvar g = 0; g < 2; g++) begin : g_bars
        assign stack_len[g] = cap_len(vid.player_stacks[g] >> 3, 11'd160);
        assign bet_len[g]   = cap_len(vid.player_pots[g] >> 3, 11'd160);
    end

    always_comb begin
        unique case (vid.curr_state)
            StPreflop: comm_vis = 3'd0;
            StFlop:    comm_vis = 3'd3;
            StTurn:    comm_vis = 3'd4;
            default:   comm_vis = 3'd5;
        endcase
    end

    // Table layers are painted back to front; later layers overwrite earlier ones.
    always_comb begin
        rgb     = 12'h000;
        hit     = '0;
        face_up = 1'b0;
        if (vid.start_state) begin
            rgb = in_rect(px, py, 11'd220, 11'd200, 11'd200, 11'd80) ? 12'hFFF : 12'h008;
        end else if (vid.wait_state) begin
            rgb = 12'h444;
        end else if (vid.game_state) begin
            rgb = 12'h062;
            if (in_rect(px, py, 11'd200, 11'd280, pot_len, 11'd8)) rgb = 12'hFFF;
            for (int p = 0; p < 2; p++) begin
                if (p == 0 || p1_en) begin
                    if (in_rect(px, py, 11'd460, (p == 1) ? 11'd44 : 11'd420, stack_len[p],
                                11'd8)) rgb = 12'hFC0;
                    if (in_rect(px, py, 11'd460, (p == 1) ? 11'd88 : 11'd380, bet_len[p],
                                11'd8)) rgb = 12'hF88;
                end
            end
            for (int p = 0; p < 2; p++) begin
`ifdef SHOW_ALL_CARDS_EN
                face_up = 1'b1;
`else
                face_up = showdown || (vid.current_player == 1'(p));
`endif
                for (int c = 0; c < 2; c++) begin
                    hit = card_px(px, py, 11'(280 + 50 * c), (p == 1) ? 11'd24 : 11'd400,
                                  vid.player_cards[p][c], face_up);
                    if (hit[12] && (p == 0 || p1_en)) rgb = hit[11:0];
                end
            end
            for (int k = 0; k < 5; k++) begin
                hit = card_px(px, py, 11'(200 + 50 * k), 11'd212, comm_cards[k], 1'b1);
                if (hit[12] && 3'(k) < comm_vis) rgb = hit[11:0];
            end
            if ((!owner || p1_en) &&
                in_rect(px, py, 11'd276, frame_top, 11'd98, 11'd64) &&
                !in_rect(px, py, 11'd278, frame_top + 11'd2, 11'd94, 11'd60)) begin
                rgb = showdown ? 12'h0F0 : 12'hFF0;
            end
            if ((!vid.current_dealer || p1_en) &&
                in_rect(px, py, 11'd384, dealer_top, 11'd12, 11'd12)) rgb = 12'hF80;
            if (in_rect(px, py, 11'd600, 11'd440, 11'd16, 11'd16)) begin
                rgb = vid.if_BetCheck ? 12'h0F0 : 12'hF00;
            end
        end
        if (!active) rgb = 12'h000;
    end

    assign vid.drawX         = draw_x_q;
    assign vid.drawY         = draw_y_q;
    assign vid.hs            = hs_q;
    assign vid.vs            = vs_q;
    assign vid.active_nblank = active;
    assign vid.sync          = 1'b0;
    assign vid.Red           = rgb[11:8];
    assign vid.Green         = rgb[7:4];
    assign vid.Blue          = rgb[3:0];

endmodule

// File: tb/tb_poker_table_video.sv
// Scoreboard bench for poker_table_video: per-line random table state, probed pixels
// checked against a layered reference model as the raster passes them.
module tb_poker_table_video;
    import poker_types_pkg::*;

    typedef struct packed {
        logic             st, wt, gm;
        logic [2:0]       count;
        card_t [1:0][1:0] cards;
        logic [1:0][10:0] stack;
        logic [1:0][10:0] pot;
        logic [10:0]      pot_size;
        logic             cp, dealer, winner, betchk;
        logic [2:0]       state;
        card_t [4:0]      comm;
    } scen_t;

    typedef struct packed {
        logic [9:0]  x, y;
        logic [11:0] rgb;
        logic        hs, vs, nb;
    } probe_t;

    localparam int NLines = 96;

    logic clk = 1'b0;
    logic reset;
    logic [9:0] mx, my;
    probe_t sb[$];
    int n_assert = 0;
    int n_fail = 0;

    always #20 clk = ~clk;

    poker_table_video_if vif ();

    poker_table_video dut (
        .clk   (clk),
        .reset (reset),
        .vid   (vif)
    );

    // Raster position the display should be at, counted from reset release.
    always @(posedge clk) begin
        if (reset) begin
            mx <= '0;
            my <= '0;
        end else if (mx == 10'd799) begin
            mx <= '0;
            my <= (my == 10'd524) ? 10'd0 : my + 10'd1;
        end else begin
            mx <= mx + 10'd1;
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic bit in_box(int x, int y, int x0, int x1, int y0, int y1);
        return x >= x0 && x <= x1 && y >= y0 && y <= y1;
    endfunction

    function automatic logic [11:0] card_face(card_t c, bit up, int rx, int ry);
        logic [11:0] ink;
        ink = (c.suit == 2'd1 || c.suit == 2'd2) ? 12'hF00 : 12'h000;
        if (!up) return 12'h00A;
        if (in_box(rx, ry, 4, 11, 4, 11)) return ink;
        if (ry >= 44 && ry <= 51 && rx >= 4 && rx < 4 + 2 * int'(c.rank)) return ink;
        return 12'hFFF;
    endfunction

    function automatic int bar(int v, int shift, int cap);
        int l;
        l = v >> shift;
        return (l > cap) ? cap : l;
    endfunction

    // Looks up the topmost layer covering (x, y); layers listed front to back.
    function automatic logic [11:0] ref_rgb(int x, int y, scen_t s);
        bit p1, sd, up;
        int owner, top, vis, cx, cy, len;
        if (!(x < 640 && y < 480)) return 12'h000;
        if (s.st) return in_box(x, y, 220, 419, 200, 279) ? 12'hFFF : 12'h008;
        if (s.wt) return 12'h444;
        if (!s.gm) return 12'h000;
        p1 = s.count >= 2;
        sd = s.state == 3'd4;
        if (in_box(x, y, 600, 615, 440, 455)) return s.betchk ? 12'h0F0 : 12'hF00;
        top = s.dealer ? 46 : 422;
        if ((!s.dealer || p1) && in_box(x, y, 384, 395, top, top + 11)) return 12'hF80;
        owner = sd ? int'(s.winner) : int'(s.cp);
        top = owner ? 20 : 396;
        if ((owner == 0 || p1) && in_box(x, y, 276, 373, top, top + 63) &&
            !in_box(x, y, 278, 371, top + 2, top + 61)) return sd ? 12'h0F0 : 12'hFF0;
        case (s.state)
            3'd0: vis = 0;
            3'd1: vis = 3;
            3'd2: vis = 4;
            default: vis = 5;
        endcase
        for (int k = 0; k < vis; k++) begin
            cx = 200 + 50 * k;
            if (in_box(x, y, cx, cx + 39, 212, 267))
                return card_face(s.comm[k], 1'b1, x - cx, y - 212);
        end
        for (int p = 0; p < 2; p++) begin
`ifdef SHOW_ALL_CARDS_EN
            up = 1'b1;
`else
            up = sd || (int'(s.cp) == p);
`endif
            cy = (p == 1) ? 24 : 400;
            for (int c = 0; c < 2; c++) begin
                cx = 280 + 50 * c;
                if ((p == 0 || p1) && in_box(x, y, cx, cx + 39, cy, cy + 55))
                    return card_face(s.cards[p][c], up, x - cx, y - cy);
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (p == 0 || p1) begin
                len = bar(int'(s.pot[p]), 3, 160);
                cy = (p == 1) ? 88 : 380;
                if (in_box(x, y, 460, 459 + len, cy, cy + 7)) return 12'hF88;
                len = bar(int'(s.stack[p]), 3, 160);
                cy = (p == 1) ? 44 : 420;
                if (in_box(x, y, 460, 459 + len, cy, cy + 7)) return 12'hFC0;
            end
        end
        if (in_box(x, y, 200, 199 + bar(int'(s.pot_size), 5, 240), 280, 287)) return 12'hFFF;
        return 12'h062;
    endfunction

    function automatic card_t rand_card();
        card_t c;
        c.rank = 4'($urandom_range(2, 14));
        c.suit = 2'($urandom_range(0, 3));
        return c;
    endfunction

    function automatic logic [10:0] rand_amount();
        case ($urandom_range(0, 5))
            0: return 11'd0;
            1: return 11'd2047;
            default: return 11'($urandom_range(0, 2047));
        endcase
    endfunction

    function automatic scen_t make_scen(int line);
        scen_t s;
        s.st = $urandom_range(0, 15) == 0;
        s.wt = $urandom_range(0, 15) == 0;
        s.gm = $urandom_range(0, 15) != 0;
        s.count = 3'($urandom_range(0, 7));
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 2; c++) s.cards[p][c] = rand_card();
            s.stack[p] = rand_amount();
            s.pot[p] = rand_amount();
        end
        for (int k = 0; k < 5; k++) s.comm[k] = rand_card();
        s.pot_size = rand_amount();
        s.cp = 1'($urandom);
        s.dealer = 1'($urandom);
        s.winner = 1'($urandom);
        s.betchk = 1'($urandom);
        s.state = 3'($urandom_range(0, 4));
        if (line == 10) s.st = 1'b1;
        if (line == 21 || line == 30 || line == 31 || line >= 44 && line <= 46) begin
            s.st = 1'b0;
            s.wt = 1'b0;
            s.gm = 1'b1;
            s.count = 3'd2;
        end
        if (line == 21 || line == 30) begin
            s.state = 3'd4;
            s.winner = 1'b1;
        end
        if (line == 30) s.cards[1][1] = '{rank: 4'd11, suit: 2'd0};
        if (line == 31) begin
            s.state = 3'd0;
            s.cp = 1'b0;
        end
        if (line == 44) s.stack[1] = 11'd1000;
        if (line == 45) s.stack[1] = 11'd2047;
        if (line == 46) s.stack[1] = 11'd0;
        return s;
    endfunction

    task automatic apply(scen_t s);
        vif.start_state    = s.st;
        vif.wait_state     = s.wt;
        vif.game_state     = s.gm;
        vif.player_count   = s.count;
        vif.player_cards   = s.cards;
        vif.player_stacks  = s.stack;
        vif.player_pots    = s.pot;
        vif.pot_size       = s.pot_size;
        vif.current_player = s.cp;
        vif.current_dealer = s.dealer;
        vif.winner         = s.winner;
        vif.if_BetCheck    = s.betchk;
        vif.curr_state     = hand_state_t'(s.state);
        vif.flop_card      = {s.comm[2], s.comm[1], s.comm[0]};
        vif.turn_card      = s.comm[3];
        vif.river_card     = s.comm[4];
    endtask

    task automatic push_probes(int line, scen_t s);
        bit sel [800];
        int pts [26] = '{0, 10, 206, 277, 278, 279, 280, 290, 306, 319, 320, 336, 372, 374,
                         384, 395, 396, 460, 584, 585, 619, 620, 639, 640, 656, 752};
        probe_t pr;
        int len;
        foreach (sel[i]) sel[i] = 1'b0;
        foreach (pts[i]) sel[pts[i]] = 1'b1;
        sel[655] = 1'b1;
        sel[751] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            len = bar(int'(s.stack[p]), 3, 160);
            sel[459 + len] = 1'b1;
            sel[460 + len] = 1'b1;
            len = bar(int'(s.pot[p]), 3, 160);
            sel[459 + len] = 1'b1;
            sel[460 + len] = 1'b1;
        end
        for (int i = 0; i < 6; i++) sel[$urandom_range(0, 799)] = 1'b1;
        for (int x = 0; x < 800; x++) begin
            if (sel[x]) begin
                pr.x   = 10'(x);
                pr.y   = 10'(line);
                pr.rgb = ref_rgb(x, line, s);
                pr.hs  = !(x >= 656 && x <= 751);
                pr.vs  = !(line >= 490 && line <= 491);
                pr.nb  = x < 640 && line < 480;
                sb.push_back(pr);
            end
        end
    endtask

    task automatic monitor_loop();
        probe_t p;
        forever begin
            @(negedge clk);
            if (!reset && sb.size() > 0 && sb[0].x == mx && sb[0].y == my) begin
                p = sb.pop_front();
                check($sformatf("rgb(%0d,%0d)", p.x, p.y),
                      {20'd0, vif.Red, vif.Green, vif.Blue}, {20'd0, p.rgb});
                check($sformatf("timing(%0d,%0d) {x,y,hs,vs,nblank,sync}", p.x, p.y),
                      {8'd0, vif.drawX, vif.drawY, vif.hs, vif.vs, vif.active_nblank, vif.sync},
                      {8'd0, p.x, p.y, p.hs, p.vs, p.nb, 1'b0});
            end
        end
    endtask

    initial begin
        scen_t s;
        int guard;
        reset = 1'b1;
        s = make_scen(-1);
        apply(s);
        fork
            monitor_loop();
        join_none
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("reset drawX", 32'(vif.drawX), 32'd0);
        check("reset drawY", 32'(vif.drawY), 32'd0);
        check("reset hs/vs", {30'd0, vif.hs, vif.vs}, 32'd3);
        @(posedge clk);
        #1;
        for (int line = 0; line < NLines; line++) begin
            s = make_scen(line);
            apply(s);
            push_probes(line, s);
            if (line == 0) reset = 1'b0;
            guard = 0;
            while (!(int'(my) == line && mx >= 10'd700) && guard < 2000) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 2000) begin
                check("line wait timeout", 32'(guard), 32'd0);
                break;
            end
        end
        guard = 0;
        while (sb.size() > 0 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("unconsumed probes", 32'(sb.size()), 32'd0);
        sb.delete();
        // Mid-frame reset must restart the raster on the very next clock.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midframe reset x/y", {12'd0, vif.drawX, vif.drawY}, 32'd0);
        check("midframe reset hs/vs", {30'd0, vif.hs, vif.vs}, 32'd3);
        @(negedge clk);
        check("first count after reset", 32'(vif.drawX), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
